// File: rtl/apu_pkg.sv
// Shared APU definitions: DMC register layout, rate tables and register decoding.
// Build with APU_DMC_PAL_EN defined to select the PAL rate table instead of NTSC.
package apu_pkg;

  localparam logic [15:0] DMC_ADDR_BASE = 16'hC000;

  typedef logic [8:0] dmc_period_t;

  typedef struct packed {
    logic       irq_en;
    logic       loop;
    logic [3:0] rate;
    logic [7:0] sample_addr;
    logic [7:0] sample_len;
  } dmc_regs_t;

  localparam dmc_period_t DMC_RATE_NTSC [16] = '{
    9'd428, 9'd380, 9'd340, 9'd320, 9'd286, 9'd254, 9'd226, 9'd214,
    9'd190, 9'd160, 9'd142, 9'd128, 9'd106, 9'd84,  9'd72,  9'd54
  };

  localparam dmc_period_t DMC_RATE_PAL [16] = '{
    9'd398, 9'd354, 9'd316, 9'd298, 9'd276, 9'd236, 9'd210, 9'd198,
    9'd176, 9'd148, 9'd132, 9'd118, 9'd98,  9'd78,  9'd66,  9'd50
  };

  // reg_array[0..3] holds the last bytes written to $4010..$4013
  function automatic dmc_regs_t get_dmc_signals(input logic [3:0][7:0] reg_array);
    dmc_regs_t s;
    s.irq_en      = reg_array[0][7];
    s.loop        = reg_array[0][6];
    s.rate        = reg_array[0][3:0];
    s.sample_addr = reg_array[2];
    s.sample_len  = reg_array[3];
    return s;
  endfunction

  function automatic dmc_period_t dmc_period(input logic [3:0] rate);
`ifdef APU_DMC_PAL_EN
    return DMC_RATE_PAL[rate];
`else
    return DMC_RATE_NTSC[rate];
`endif
  endfunction

endpackage

// File: rtl/dmc_sample_fifo.sv
// Small byte FIFO holding fetched DMC sample bytes; the head byte is readable
// without a pop so the output unit can load it on the same cycle it pops.
module dmc_sample_fifo #(
  parameter  int DEPTH = 1,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr_reg] <= push_data;
        wr_ptr_reg      <= ptr_inc(wr_ptr_reg);
      end
      if (pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr_reg];
  assign count    = count_reg;

endmodule

// File: rtl/dmc_channel.sv
// APU delta-modulation sample channel: fetches bytes over a req/ack port, plays them
// as 7-bit delta steps and flags IRQ at sample end. APU_DMC_PAL_EN selects PAL rates.
module dmc_channel
  import apu_pkg::*;
#(
  parameter int BUF_DEPTH = 1,
  parameter int OUT_W     = 7
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             cpu_clk_en,
  input  logic             reg_wr,
  input  logic [1:0]       reg_sel,
  input  logic [7:0]       reg_data,
  input  logic             status_wr,
  input  logic             enable,
  output logic             mem_req,
  output logic [15:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [7:0]       mem_data,
  output logic             active,
  output logic             irq,
  output logic [OUT_W-1:0] out
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic {IDLE, REQ} rd_state_t;

  logic [3:0][7:0] regs_reg;
  dmc_regs_t       dmc;
  logic [15:0]     sample_start;
  logic [11:0]     sample_len;
  logic            unused_reg_bits;

  logic [8:0]  timer_reg;
  logic        out_clk;
  logic [7:0]  shift_reg;
  logic [3:0]  bits_reg;
  logic        silence_reg;
  logic [6:0]  level_reg, level_next;
  logic [OUT_W-1:0] out_reg;

  rd_state_t   state_reg, state_next;
  logic [15:0] mem_addr_reg;
  logic [15:0] cur_addr_reg, cur_addr_next;
  logic [11:0] bytes_reg, bytes_next;
  logic        irq_reg, irq_next;
  logic        fetch_done;

  logic          fifo_pop;
  logic [7:0]    fifo_data;
  logic [CW-1:0] fifo_count;

  assign dmc             = get_dmc_signals(regs_reg);
  assign sample_start    = DMC_ADDR_BASE + {2'b00, dmc.sample_addr, 6'b000000};
  assign sample_len      = {dmc.sample_len, 4'h0} + 12'd1;
  assign unused_reg_bits = ^{regs_reg[0][5:4], regs_reg[1]};

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) regs_reg <= '0;
    else if (reg_wr) regs_reg[reg_sel] <= reg_data;
  end

  assign out_clk = cpu_clk_en && (timer_reg == '0);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) timer_reg <= dmc_period(4'd0) - 9'd1;
    else if (cpu_clk_en) timer_reg <= out_clk ? dmc_period(dmc.rate) - 9'd1 : timer_reg - 9'd1;
  end

  // The next byte is loaded as the last bit of the current one is shifted out.
  assign fifo_pop = out_clk && (bits_reg == 4'd1) && (fifo_count != '0);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      shift_reg   <= '0;
      bits_reg    <= 4'd8;
      silence_reg <= 1'b1;
    end else if (out_clk) begin
      shift_reg <= shift_reg >> 1;
      if (bits_reg == 4'd1) begin
        bits_reg <= 4'd8;
        if (fifo_count != '0) begin
          shift_reg   <= fifo_data;
          silence_reg <= 1'b0;
        end else begin
          silence_reg <= 1'b1;
        end
      end else begin
        bits_reg <= bits_reg - 4'd1;
      end
    end
  end

  // A direct $4011 load overrides any delta step landing in the same cycle.
  always_comb begin
    level_next = level_reg;
    if (out_clk && !silence_reg) begin
      if (shift_reg[0] && level_reg <= 7'd125)      level_next = level_reg + 7'd2;
      else if (!shift_reg[0] && level_reg >= 7'd2) level_next = level_reg - 7'd2;
    end
    if (reg_wr && reg_sel == 2'd1) level_next = reg_data[6:0];
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      level_reg <= '0;
      out_reg   <= '0;
    end else begin
      level_reg <= level_next;
      out_reg   <= OUT_W'(level_next) << (OUT_W - 7);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (fifo_count < CW'(BUF_DEPTH) && bytes_reg != '0) state_next = REQ;
      REQ:     if (mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign fetch_done = (state_reg == REQ) && mem_ack;

  // A fetch already in flight when the channel is disabled still lands in the buffer.
  always_comb begin
    cur_addr_next = cur_addr_reg;
    bytes_next    = bytes_reg;
    irq_next      = irq_reg;
    if (fetch_done) begin
      cur_addr_next = (cur_addr_reg == 16'hFFFF) ? 16'h8000 : cur_addr_reg + 16'd1;
      if (bytes_reg != '0) begin
        bytes_next = bytes_reg - 12'd1;
        if (bytes_reg == 12'd1) begin
          if (dmc.loop) begin
            cur_addr_next = sample_start;
            bytes_next    = sample_len;
          end else if (dmc.irq_en) begin
            irq_next = 1'b1;
          end
        end
      end
    end
    if (status_wr) begin
      irq_next = 1'b0;
      if (!enable) begin
        bytes_next = '0;
      end else if (bytes_reg == '0) begin
        cur_addr_next = sample_start;
        bytes_next    = sample_len;
      end
    end
    if (reg_wr && reg_sel == 2'd0 && !reg_data[7]) irq_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg    <= IDLE;
      mem_addr_reg <= DMC_ADDR_BASE;
      cur_addr_reg <= DMC_ADDR_BASE;
      bytes_reg    <= '0;
      irq_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cur_addr_reg <= cur_addr_next;
      bytes_reg    <= bytes_next;
      irq_reg      <= irq_next;
      if (state_reg == IDLE && state_next == REQ) mem_addr_reg <= cur_addr_reg;
    end
  end

  dmc_sample_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_l     (rst_l),
    .push      (fetch_done),
    .push_data (mem_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .count     (fifo_count)
  );

  assign mem_req  = (state_reg == REQ);
  assign mem_addr = mem_addr_reg;
  assign active   = (bytes_reg != '0);
  assign irq      = irq_reg;
  assign out      = out_reg;

endmodule

// File: tb/tb_dmc_channel.sv
// Directed bench for dmc_channel: a memory responder checks fetch addresses against an
// expected-address queue, and output levels are checked against an expected-level queue.
module tb_dmc_channel;

  localparam int BUF_DEPTH = 4;
  localparam int OUT_W     = 8;
  localparam int SH        = OUT_W - 7;

  logic             clk = 1'b0;
  logic             rst_l;
  logic             cpu_clk_en;
  logic             reg_wr;
  logic [1:0]       reg_sel;
  logic [7:0]       reg_data;
  logic             status_wr;
  logic             enable;
  logic             mem_req;
  logic [15:0]      mem_addr;
  logic             mem_ack;
  logic [7:0]       mem_data;
  logic             active;
  logic             irq;
  logic [OUT_W-1:0] out;

  int   checks    = 0;
  int   errors    = 0;
  int   fetch_cnt = 0;
  int   ack_delay = 0;
  int   wait_cnt  = 0;
  bit   resp_en   = 1'b1;
  logic [7:0]       resp_data = 8'h00;
  logic [15:0]      addr_q [$];
  logic [OUT_W-1:0] level_q [$];

  dmc_channel #(.BUF_DEPTH(BUF_DEPTH), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .cpu_clk_en (cpu_clk_en),
    .reg_wr     (reg_wr),
    .reg_sel    (reg_sel),
    .reg_data   (reg_data),
    .status_wr  (status_wr),
    .enable     (enable),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .active     (active),
    .irq        (irq),
    .out        (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] sel, input logic [7:0] d);
    reg_wr = 1'b1; reg_sel = sel; reg_data = d;
    tick();
    reg_wr = 1'b0;
  endtask

  task automatic status_write(input logic en);
    status_wr = 1'b1; enable = en;
    tick();
    status_wr = 1'b0;
  endtask

  task automatic wait_fetch(input int target, input int budget, input string tag);
    int n = 0;
    while (fetch_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, fetch_cnt, target);
  endtask

  task automatic wait_out_change(input int budget, output int cycles);
    logic [OUT_W-1:0] prev;
    prev   = out;
    cycles = 0;
    while (out === prev && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  // Memory responder: acknowledges each request after ack_delay cycles.
  initial begin
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (!resp_en || !mem_req) begin
        wait_cnt = 0;
      end else if (wait_cnt < ack_delay) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        checks++;
        assert (addr_q.size() != 0) else begin
          errors++;
          $error("FAIL fetch_extra observed addr %h expected no request", mem_addr);
        end
        if (addr_q.size() != 0) check("fetch_addr", mem_addr, addr_q.pop_front());
        $display("fetch %0d addr %h data %h", fetch_cnt, mem_addr, resp_data);
        mem_data = resp_data;
        mem_ack  = 1'b1;
        fetch_cnt++;
      end
    end
  end

  initial begin
    int base;
    int cyc;
    int changes;
    int n;

    rst_l = 1'b0; cpu_clk_en = 1'b1; reg_wr = 1'b0; reg_sel = 2'd0; reg_data = 8'h00;
    status_wr = 1'b0; enable = 1'b0;
    repeat (3) tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 16'hC000);
    check("rst_irq", irq, 0);
    check("rst_active", active, 0);
    check("rst_out", out, 0);
    rst_l = 1'b1;
    tick();

    // 1: direct level load, held while silent
    reg_write(2'd0, 8'h0F);
    reg_write(2'd1, 8'h40);
    check("t1_out", out, 32'(64 << SH));
    changes = 0;
    repeat (1100) begin
      tick();
      if (out !== OUT_W'(64 << SH)) changes++;
    end
    check("t1_hold", changes, 0);
    check("t1_nofetch", fetch_cnt, 0);

    // 2: one-byte sample of all ones
    reg_write(2'd2, 8'h00);
    reg_write(2'd3, 8'h00);
    resp_data = 8'hFF;
    addr_q.push_back(16'hC000);
    for (int k = 1; k <= 8; k++) level_q.push_back(OUT_W'((64 + 2 * k) << SH));
    base = fetch_cnt;
    status_write(1'b1);
    check("t2_active", active, 1);
    for (int k = 0; k < 8; k++) begin
      wait_out_change((k == 0) ? 1000 : 60, cyc);
      check("t2_level", out, level_q.pop_front());
      if (k > 0) check("t2_interval", cyc, 54);
    end
    wait_out_change(200, cyc);
    check("t2_settle", cyc, 200);
    check("t2_active_end", active, 0);
    check("t2_fetches", fetch_cnt, base + 1);
    check("t2_addr_q", addr_q.size(), 0);

    // 3: 17-byte sample with IRQ
    reg_write(2'd0, 8'h8F);
    reg_write(2'd2, 8'h00);
    reg_write(2'd3, 8'h01);
    resp_data = 8'h00;
    for (int i = 0; i < 17; i++) addr_q.push_back(16'hC000 + 16'(i));
    base = fetch_cnt;
    status_write(1'b1);
    wait_fetch(base + 16, 9000, "t3_fetch16");
    check("t3_irq_pre", irq, 0);
    wait_fetch(base + 17, 1000, "t3_fetch17");
    check("t3_irq_set", irq, 1);
    check("t3_active", active, 0);
    check("t3_addr_q", addr_q.size(), 0);
    status_write(1'b0);
    check("t3_irq_clr", irq, 0);
    repeat (500) tick();
    check("t3_no_more", fetch_cnt, base + 17);

    // 4: looping one-byte sample
    reg_write(2'd0, 8'h4F);
    reg_write(2'd3, 8'h00);
    for (int i = 0; i < 6; i++) addr_q.push_back(16'hC000);
    base = fetch_cnt;
    status_write(1'b1);
    wait_fetch(base + 6, 4000, "t4_fetch6");
    check("t4_active_loop", active, 1);
    check("t4_irq", irq, 0);
    status_write(1'b0);
    check("t4_active_off", active, 0);
    repeat (1000) tick();
    check("t4_stopped", fetch_cnt, base + 6);
    check("t4_irq_end", irq, 0);

    // 5: address wrap FFFF -> 8000
    reg_write(2'd0, 8'h0F);
    reg_write(2'd2, 8'hFF);
    reg_write(2'd3, 8'h04);
    for (int i = 0; i < 64; i++) addr_q.push_back(16'hFFC0 + 16'(i));
    addr_q.push_back(16'h8000);
    base = fetch_cnt;
    status_write(1'b1);
    wait_fetch(base + 65, 32000, "t5_fetch65");
    check("t5_active", active, 0);
    check("t5_addr_q", addr_q.size(), 0);

    // 6: slow acknowledge, register write mid-request, reset mid-fetch
    ack_delay = 20;
    reg_write(2'd2, 8'h00);
    reg_write(2'd3, 8'h00);
    addr_q.push_back(16'hC000);
    status_write(1'b1);
    n = 0;
    while (!mem_req && n < 1000) begin
      tick();
      n++;
    end
    check("t6_req", mem_req, 1);
    check("t6_addr", mem_addr, 16'hC000);
    reg_write(2'd2, 8'h10);
    check("t6_addr_hold", mem_addr, 16'hC000);
    reg_write(2'd1, 8'h55);
    check("t6_level", out, 32'(8'h55 << SH));
    check("t6_req_hold", mem_req, 1);
    check("t6_active", active, 1);
    resp_en = 1'b0;
    rst_l   = 1'b0;
    #1;
    check("t6_rst_req", mem_req, 0);
    check("t6_rst_out", out, 0);
    check("t6_rst_active", active, 0);
    addr_q.delete();
    repeat (3) tick();
    rst_l   = 1'b1;
    resp_en = 1'b1;
    repeat (50) tick();
    check("t6_post_req", mem_req, 0);
    check("t6_post_irq", irq, 0);
    check("t6_post_out", out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
